// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared op/state enums and read-only range for the CSR arbiter
package csr_pkg;

  typedef enum logic [1:0] {
    OP_RW   = 2'd0,
    OP_RS   = 2'd1,
    OP_RC   = 2'd2,
    OP_RSVD = 2'd3
  } csr_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_e;

  localparam logic [11:0] RO_BASE = 12'hC00;
  localparam logic [11:0] RO_LAST = 12'hCFF;

  function automatic logic in_ro_range(input logic [31:0] addr);
    return (addr >= {20'd0, RO_BASE}) && (addr <= {20'd0, RO_LAST});
  endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// rtl/csr_rmw_alu.sv - combinational read-modify-write for RW/RS/RC CSR ops
module csr_rmw_alu import csr_pkg::*; #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] old,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] new_data,
  output logic                  write_en
);

  // Set/clear with an all-zero mask is a pure read and must not touch the CSR
  always_comb begin
    new_data = old;
    write_en = 1'b0;
    case (csr_op_e'(op))
      OP_RW: begin
        new_data = wdata;
        write_en = 1'b1;
      end
      OP_RS: begin
        new_data = old | wdata;
        write_en = |wdata;
      end
      OP_RC: begin
        new_data = old & ~wdata;
        write_en = |wdata;
      end
      default: begin
        new_data = old;
        write_en = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_arbiter.sv
// rtl/csr_arbiter.sv - two-requester round-robin arbiter sequencing CSR read-modify-write
module csr_arbiter import csr_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [3:0]              req_op,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  input  logic                    flush,
  output logic [1:0]              rsp_valid,
  output logic                    rsp_err,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [ADDR_WIDTH-1:0]   csr_addr,
  output logic                    csr_rd_en,
  input  logic [DATA_WIDTH-1:0]   csr_rdata,
  output logic                    csr_wr_en,
  output logic [DATA_WIDTH-1:0]   csr_wdata,
  output logic                    busy
);

  state_e                state_q, state_d;
  csr_op_e               op_q;
  logic                  last_grant_q, owner_q, err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, old_q;
  logic                  gnt, hs, err_now, alu_we;
  logic [DATA_WIDTH-1:0] alu_new;

  csr_rmw_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op       (op_q),
    .old      (csr_rdata),
    .wdata    (wdata_q),
    .new_data (alu_new),
    .write_en (alu_we)
  );

  // Read-only range only faults when the op would actually modify the CSR
  assign err_now = (op_q == OP_RSVD) || (in_ro_range(32'(addr_q)) && alu_we);

  always_comb begin
    case (req_valid)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last_grant_q;
      default: gnt = 1'b0;
    endcase
  end

  assign hs = (state_q == S_IDLE) && !rst && req_valid[gnt];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= OP_RW;
      addr_q       <= '0;
      wdata_q      <= '0;
      old_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        owner_q      <= gnt;
        last_grant_q <= gnt;
        op_q         <= csr_op_e'(gnt ? req_op[3:2] : req_op[1:0]);
        addr_q       <= gnt ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
        wdata_q      <= gnt ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
      end
      if (state_q == S_WRITE) begin
        old_q <= csr_rdata;
        err_q <= err_now;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    csr_addr  = '0;
    csr_rd_en = 1'b0;
    csr_wr_en = 1'b0;
    csr_wdata = '0;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          req_ready[gnt] = 1'b1;
          state_d        = S_READ;
        end
      end
      S_READ: begin
        csr_rd_en = 1'b1;
        csr_addr  = addr_q;
        // Only the pipeline's own transactions are cancelled, and only before any side effect
        state_d   = (flush && !owner_q) ? S_IDLE : S_WRITE;
      end
      S_WRITE: begin
        csr_addr  = addr_q;
        csr_wr_en = alu_we && !err_now;
        csr_wdata = csr_wr_en ? alu_new : '0;
        state_d   = S_RESP;
      end
      S_RESP: begin
        rsp_valid[owner_q] = 1'b1;
        rsp_rdata          = old_q;
        rsp_err            = err_q;
        state_d            = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);

endmodule
